fetch_unit: RTL and testbench

Instruction-fetch and condition-code stage that sits directly upstream of the multicycle `controller`. It reads a 16-bit LC-3b instruction from byte-wide memory as two little-endian byte reads, holds it in the instruction register that drives the controller's `IR` input, and maintains the N/Z/P condition-code flags the controller uses for branch decisions.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Byte-wide instruction memory bus between the fetch unit and memory.
//   mem_addr  : byte address driven by the fetch unit
//   mem_rd    : read request, held until mem_ack
//   mem_rdata : read data, valid in the cycle mem_ack is high
//   mem_ack   : memory completed the current byte read
// master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Fetches a 16-bit LC-3b instruction as two little-endian byte reads, holds it
// in IR for the downstream controller, and keeps the N/Z/P condition codes.
//   clk, rst_n   : clock, asynchronous active-low reset
//   fetch_req    : start a fetch at pc_in (sampled only when idle)
//   pc_in        : instruction byte address, must be even
//   mem          : byte memory bus (fetch_unit_if.master)
//   IR           : instruction register
//   ir_valid     : one-cycle pulse, IR just updated
//   busy         : fetch in progress
//   fetch_err    : one-cycle pulse, misaligned pc_in rejected
//   lccr/cc_data : load condition codes from cc_data
//   N, Z, P      : condition-code flags
// ---------------------------------------------------------------------------
module fetch_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fetch_req,
    input  logic [15:0]  pc_in,
    fetch_unit_if.master mem,
    output logic [15:0]  IR,
    output logic         ir_valid,
    output logic         busy,
    output logic         fetch_err,
    input  logic         lccr,
    input  logic [15:0]  cc_data,
    output logic         N,
    output logic         Z,
    output logic         P
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD_LO = 2'd1;
    localparam logic [1:0] RD_HI = 2'd2;

    logic [1:0]  state;
    logic [15:0] addr;
    logic [7:0]  lo_byte;

    logic accept;
    assign accept = (state == IDLE) && fetch_req && !pc_in[0];

    // Control state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            IR        <= 16'h0000;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        if (pc_in[0]) begin
                            fetch_err <= 1'b1;
                        end else begin
                            state <= RD_LO;
                        end
                    end
                end
                RD_LO: begin
                    if (mem.mem_ack) begin
                        state <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (mem.mem_ack) begin
                        IR       <= {mem.mem_rdata, lo_byte};
                        ir_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and low-byte holding registers carry no reset: they are only
    // observed while the FSM is in RD_LO/RD_HI, so an aborted fetch simply
    // leaves stale data that the next fetch overwrites.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr <= pc_in;
        end
        if ((state == RD_LO) && mem.mem_ack) begin
            lo_byte <= mem.mem_rdata;
        end
    end

    // Condition codes, independent of the fetch FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N <= 1'b0;
            Z <= 1'b1;
            P <= 1'b0;
        end else if (lccr) begin
            N <= cc_data[15];
            Z <= (cc_data == 16'h0000);
            P <= !cc_data[15] && (cc_data != 16'h0000);
        end
    end

    // Bus outputs decode straight from state flops; addr is even, so the
    // high byte address is formed by setting bit 0 (no carry at 0xFFFE).
    always_comb begin
        mem.mem_addr = 16'h0000;
        case (state)
            RD_LO:   mem.mem_addr = addr;
            RD_HI:   mem.mem_addr = {addr[15:1], 1'b1};
            default: mem.mem_addr = 16'h0000;
        endcase
    end

    assign mem.mem_rd = (state != IDLE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model of the fetch unit.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] pc_in;
    logic [15:0] IR;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;
    logic        lccr;
    logic [15:0] cc_data;
    logic        N, Z, P;

    fetch_unit_if mem_bus ();

    fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req),
        .pc_in     (pc_in),
        .mem       (mem_bus),
        .IR        (IR),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fetch_err (fetch_err),
        .lccr      (lccr),
        .cc_data   (cc_data),
        .N         (N),
        .Z         (Z),
        .P         (P)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h3000: return 8'h34;
            16'h3001: return 8'h12;
            16'hFFFE: return 8'hCD;
            16'hFFFF: return 8'hAB;
            default:  return (a[7:0] ^ a[15:8]) + 8'h3B;
        endcase
    endfunction

    // Memory responder: per byte, wait cur_lat cycles then ack for one cycle
    int fix_lat  = 0;
    bit rand_lat = 1'b0;
    bit stray    = 1'b0;

    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mem_bus.mem_rd) begin
                if (cnt >= cur_lat) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = mem_byte(mem_bus.mem_addr);
                    cnt = 0;
                    cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
                end else begin
                    mem_bus.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                cnt = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
                mem_bus.mem_ack   = stray && ($urandom_range(0, 3) == 0);
                mem_bus.mem_rdata = 8'($urandom);
            end
        end
    end

    // Transaction-level model: one outstanding fetch, counting acked bytes
    bit          m_active = 1'b0;
    logic [15:0] m_pc     = 16'h0;
    int          m_nacks  = 0;
    logic [15:0] m_ir     = 16'h0;
    bit          m_irv    = 1'b0;
    bit          m_err    = 1'b0;
    logic [15:0] m_cc     = 16'h0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_nacks  = 0;
                m_ir     = 16'h0;
                m_irv    = 1'b0;
                m_err    = 1'b0;
                m_cc     = 16'h0;
            end else begin
                m_irv = 1'b0;
                m_err = 1'b0;
                if (!m_active) begin
                    if (fetch_req) begin
                        if (pc_in % 2 == 1) begin
                            m_err = 1'b1;
                        end else begin
                            m_active = 1'b1;
                            m_pc     = pc_in;
                            m_nacks  = 0;
                        end
                    end
                end else if (mem_bus.mem_ack) begin
                    if (m_nacks == 0) begin
                        m_nacks = 1;
                    end else begin
                        m_ir     = {mem_byte(m_pc + 16'd1), mem_byte(m_pc)};
                        m_irv    = 1'b1;
                        m_active = 1'b0;
                    end
                end
                if (lccr) m_cc = cc_data;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic en, ez, ep;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                en = m_cc[15];
                ez = (m_cc == 16'h0);
                ep = !en && !ez;
                chk("mem_rd",    mem_bus.mem_rd, m_active);
                chk("mem_addr",  mem_bus.mem_addr, m_active ? m_pc + 16'(m_nacks) : 16'h0);
                chk("busy",      busy, m_active);
                chk("ir_valid",  ir_valid, m_irv);
                chk("IR",        IR, m_ir);
                chk("fetch_err", fetch_err, m_err);
                chk("NZP",       {N, Z, P}, {en, ez, ep});
                chk("onehot",    32'(N) + 32'(Z) + 32'(P), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irv(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ir_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("irv_timeout", ok, 1);
    endtask

    initial begin
        logic [2:0]  exp_nzp;
        bit          found;
        rst_n     = 1'b1;
        fetch_req = 1'b0;
        pc_in     = 16'h0;
        lccr      = 1'b0;
        cc_data   = 16'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_IR", IR, 16'h0000);
        chk("rst_NZP", {N, Z, P}, 3'b010);
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_bus.mem_rd, 0);

        // Zero-wait fetch at 0x3000
        tick();
        fetch_req = 1'b1; pc_in = 16'h3000;
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("zw_addr_lo", mem_bus.mem_addr, 16'h3000);
        chk("zw_rd_c1", mem_bus.mem_rd, 1);
        @(negedge clk);
        chk("zw_addr_hi", mem_bus.mem_addr, 16'h3001);
        @(negedge clk);
        chk("zw_irv_c3", ir_valid, 1);
        chk("zw_IR", IR, 16'h1234);
        chk("zw_busy_c3", busy, 0);

        // Two wait states per byte: ir_valid in cycle 7
        fix_lat = 2;
        tick(); tick();
        fetch_req = 1'b1; pc_in = 16'h3000;
        tick();
        fetch_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("ws_addr", mem_bus.mem_addr, (c <= 3) ? 16'h3000 : (c <= 6) ? 16'h3001 : 16'h0000);
            chk("ws_rd", mem_bus.mem_rd, (c <= 6) ? 1 : 0);
            chk("ws_irv", ir_valid, (c == 7) ? 1 : 0);
        end
        chk("ws_IR", IR, 16'h1234);

        // Misaligned request
        tick();
        fetch_req = 1'b1; pc_in = 16'h3001;
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("mis_err", fetch_err, 1);
        chk("mis_rd", mem_bus.mem_rd, 0);
        @(negedge clk);
        chk("mis_err_off", fetch_err, 0);
        chk("mis_IR", IR, 16'h1234);

        // Second request while busy is dropped
        tick();
        fetch_req = 1'b1; pc_in = 16'h3000;
        tick();
        fetch_req = 1'b1; pc_in = 16'h4000;
        tick();
        fetch_req = 1'b0;
        wait_irv(20);
        chk("busyreq_IR", IR, 16'h1234);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("busyreq_no_queue", mem_bus.mem_rd, 0);
        end

        // Condition codes
        for (int k = 0; k < 3; k++) begin
            tick();
            lccr = 1'b1;
            cc_data = (k == 0) ? 16'h8000 : (k == 1) ? 16'h0000 : 16'h0001;
            exp_nzp = (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
            tick();
            lccr = 1'b0;
            @(negedge clk);
            chk("cc_NZP", {N, Z, P}, exp_nzp);
        end

        // Reset in RD_HI aborts immediately
        fix_lat = 3;
        tick(); tick();
        fetch_req = 1'b1; pc_in = 16'h3000;
        tick();
        fetch_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_bus.mem_addr == 16'h3001) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reach_rdhi", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rd", mem_bus.mem_rd, 0);
        chk("mid_busy", busy, 0);
        chk("mid_IR", IR, 16'h0000);
        chk("mid_irv", ir_valid, 0);
        chk("mid_NZP", {N, Z, P}, 3'b010);
        tick();
        rst_n = 1'b1;
        fix_lat = 0;
        tick(); tick();
        fetch_req = 1'b1; pc_in = 16'h3000;
        tick();
        fetch_req = 1'b0;
        wait_irv(20);
        chk("post_rst_IR", IR, 16'h1234);

        // Boundary address with lccr on the final ack
        tick();
        fetch_req = 1'b1; pc_in = 16'hFFFE;
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("bd_addr_lo", mem_bus.mem_addr, 16'hFFFE);
        tick();
        lccr = 1'b1; cc_data = 16'h8001;
        @(negedge clk);
        chk("bd_addr_hi", mem_bus.mem_addr, 16'hFFFF);
        tick();
        lccr = 1'b0;
        @(negedge clk);
        chk("bd_irv", ir_valid, 1);
        chk("bd_IR", IR, 16'hABCD);
        chk("bd_NZP", {N, Z, P}, 3'b100);

        // Randomized traffic
        rand_lat = 1'b1;
        stray    = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            fetch_req = ($urandom_range(0, 2) == 0);
            pc_in = 16'($urandom);
            if ($urandom_range(0, 3) != 0) pc_in[0] = 1'b0;
            lccr = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       cc_data = 16'h0000;
                1:       cc_data = 16'h8000;
                default: cc_data = 16'($urandom);
            endcase
        end
        tick();
        fetch_req = 1'b0;
        lccr = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
